pll_seq_ctrl: RTL
=================

Name: pll_seq_ctrl

Overview:
Sequencer for the board rPLL in dynamic-select mode; runs on the 18 MHz crystal clock, never on the PLL output.
- Drives the PLL's IDSEL/FBDSEL/ODSEL and RESET, selecting from four frequency presets.
- Waits for LOCK with timeout, then requires LOCK to stay stable before releasing the system reset to the PDP-11 core domain.
- Presets can be re-selected at run time for CPU speed switching.

Parameters:
RST_CYCLES, 16, clk cycles pll_reset is held high per attempt (min 2).
LOCK_TIMEOUT, 65535, clk cycles to wait for synced lock before fault (~3.6 ms).
STABLE_CYCLES, 1024, consecutive cycles lock must be high before run.
SYNC_STAGES, 2, flops on the lock synchroniser (min 2).
MAX_RETRY, 3, attempts before fault; used only with PLL_AUTORETRY_EN.

Ports:
clk  in  1  18 MHz reference clock
reset  in  1  synchronous, active-high
lock  in  1  PLL LOCK, asynchronous to clk
req  in  1  single-cycle request to apply req_preset
req_preset  in  2  preset index sampled when req=1 is accepted
pll_reset  out  1  to rPLL RESET
idsel  out  6  to rPLL IDSEL (encoded)
fbdsel  out  6  to rPLL FBDSEL (encoded)
odsel  out  6  to rPLL ODSEL (encoded)
sys_reset  out  1  active-high reset for the core; resynchronised downstream
ready  out  1  1 only in RUN
fault  out  1  1 only in FAULT
cur_preset  out  2  preset currently applied

Behaviour:
- Reset (sync, reset=1) sets:
  - state=PLL_RST, counters=0, cur_preset=0, selects=preset 0 encoding.
  - pll_reset=1, sys_reset=1, ready=0, fault=0.
- Lock input: passes SYNC_STAGES flops before use (lock_s). Latency from lock to FSM = SYNC_STAGES cycles.
- PLL_RST:
  - pll_reset=1, sys_reset=1.
  - Counts RST_CYCLES, then goes to WAIT_LOCK and clears the counter.
  - Selects are updated on entry and stay stable for the whole state.
- WAIT_LOCK:
  - pll_reset=0.
  - lock_s=1: go to STABLE.
  - Counter reaching LOCK_TIMEOUT-1: go to FAULT.
- STABLE:
  - Counts consecutive lock_s=1 cycles.
  - lock_s=0: counter clears and state returns to WAIT_LOCK; the timeout counter restarts.
  - After STABLE_CYCLES: go to RUN.
- RUN:
  - sys_reset=0, ready=1.
  - lock_s=0: go to PLL_RST with sys_reset=1 in the same cycle as the transition (registered, 1-cycle latency).
  - Re-apply uses the same preset.
- FAULT:
  - fault=1, sys_reset=1, pll_reset=1.
  - Held until reset or an accepted req.
- req handling:
  - Accepted only in RUN or FAULT.
  - On acceptance: latch req_preset into cur_preset, load the encoded selects, go to PLL_RST.
  - Ignored in PLL_RST, WAIT_LOCK and STABLE; no queuing, so the requester must watch ready/fault.
- Simultaneous req and lock loss in RUN: req wins, and the new preset is applied.
- Select outputs change only on the cycle of entry to PLL_RST, so they are never changed while pll_reset=0.
- Counters are 16-bit saturating; no wrap-around is possible.
- Preset table (pkg), 18 MHz in:
  - 0 = 72 MHz (IDIV 0, FBDIV 3, ODIV 8)
  - 1 = 54 MHz (0, 2, 8)
  - 2 = 36 MHz (0, 1, 16)
  - 3 = 90 MHz (0, 4, 8)
- Encoding (Gowin dynamic-select convention):
  - idsel = 63-IDIV
  - fbdsel = 63-FBDIV
  - odsel from the Gowin ODIV table (8 -> 6'b111100, 16 -> 6'b111000)

Optional Feature:
PLL_AUTORETRY_EN.
- Defined:
  - A timeout in WAIT_LOCK returns to PLL_RST and increments a retry counter.
  - FAULT is entered only after MAX_RETRY failed attempts.
  - The retry counter clears on reaching RUN and on an accepted req.
- Undefined: the first timeout goes directly to FAULT, and no retry counter is synthesised.

Decomposition:
- Package pll_seq_pkg holds:
  - the state enum (PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT)
  - the preset record type {idsel, fbdsel, odsel}
  - the 4-entry encoded preset constant table
  - the IDIV/FBDIV/ODIV-to-select encode functions
- One sub-module: pll_lock_sync, the parameterised SYNC_STAGES flop chain for lock.

Test Plan:
- Reset then lock rises 100 cycles after pll_reset falls, held high -> pll_reset high 16 cycles; sys_reset falls at 16+100+2+1024 (±1); ready=1; fbdsel=6'd60.
- In RUN, req=1 with req_preset=2 -> next cycle pll_reset=1, cur_preset=2, fbdsel=6'd62, odsel=6'b111000; relock completes to RUN.
- Lock never rises -> fault=1 at 16+65535 cycles (no macro); with PLL_AUTORETRY_EN, fault only after 3 timeouts with 3 pll_reset pulses.
- Lock glitch low for 5 cycles at STABLE count 500 -> counter restarts and sys_reset stays 1 until a further 1024 stable cycles.
- Lock drops in RUN -> sys_reset=1 within SYNC_STAGES+1 cycles; PLL re-reset with an unchanged preset.
- req asserted during WAIT_LOCK -> ignored, cur_preset unchanged; reset asserted mid-STABLE -> all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// -----------------------------------------------------------------------------
// pll_seq_pkg
// Shared types and constants for the rPLL sequencer:
//   - state_t    : sequencer states
//   - preset_t   : encoded {idsel, fbdsel, odsel} triple for one preset
//   - PRESET_TBL : the four encoded frequency presets (18 MHz reference)
//   - enc_*      : IDIV/FBDIV/ODIV to Gowin dynamic-select encoders
// -----------------------------------------------------------------------------
package pll_seq_pkg;

    localparam int unsigned SEL_W     = 6;
    localparam int unsigned PRESET_W  = 2;
    localparam int unsigned N_PRESETS = 4;
    localparam int unsigned CNT_W     = 16;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } state_t;

    typedef logic [SEL_W-1:0]    sel_t;
    typedef logic [PRESET_W-1:0] preset_idx_t;
    typedef logic [CNT_W-1:0]    cnt_t;

    typedef struct packed {
        sel_t idsel;
        sel_t fbdsel;
        sel_t odsel;
    } preset_t;

    // Dynamic-select inputs are the one's complement of the divider value.
    function automatic sel_t enc_idiv(input int unsigned idiv);
        return SEL_W'(63 - idiv);
    endfunction

    function automatic sel_t enc_fbdiv(input int unsigned fbdiv);
        return SEL_W'(63 - fbdiv);
    endfunction

    // ODIV uses a lookup rather than a linear code.
    function automatic sel_t enc_odiv(input int unsigned odiv);
        sel_t code;
        case (odiv)
            2:       code = 6'b111111;
            4:       code = 6'b111110;
            8:       code = 6'b111100;
            16:      code = 6'b111000;
            32:      code = 6'b110000;
            48:      code = 6'b101000;
            64:      code = 6'b100000;
            80:      code = 6'b011000;
            96:      code = 6'b010000;
            112:     code = 6'b001000;
            128:     code = 6'b000000;
            default: code = 6'b111100;
        endcase
        return code;
    endfunction

    function automatic preset_t mk_preset(input int unsigned idiv,
                                          input int unsigned fbdiv,
                                          input int unsigned odiv);
        preset_t p;
        p.idsel  = enc_idiv(idiv);
        p.fbdsel = enc_fbdiv(fbdiv);
        p.odsel  = enc_odiv(odiv);
        return p;
    endfunction

    // Index 0: 72 MHz, 1: 54 MHz, 2: 36 MHz, 3: 90 MHz.
    localparam preset_t [N_PRESETS-1:0] PRESET_TBL = {
        mk_preset(0, 4, 8),
        mk_preset(0, 1, 16),
        mk_preset(0, 2, 8),
        mk_preset(0, 3, 8)
    };

    // Counters stick at all-ones instead of wrapping.
    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pll_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// pll_seq_ctrl_if
// Bundles the PLL-facing and requester-facing signals of pll_seq_ctrl.
//   lock        : PLL LOCK (asynchronous)
//   req         : single-cycle preset change request
//   req_preset  : preset index for req
//   pll_reset   : rPLL RESET
//   idsel/fbdsel/odsel : encoded rPLL dynamic selects
//   sys_reset   : core-domain reset, active high
//   ready/fault : sequencer status
//   cur_preset  : preset currently applied
// master = requester/PLL model side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface pll_seq_ctrl_if;
    import pll_seq_pkg::*;

    logic        lock;
    logic        req;
    preset_idx_t req_preset;
    logic        pll_reset;
    sel_t        idsel;
    sel_t        fbdsel;
    sel_t        odsel;
    logic        sys_reset;
    logic        ready;
    logic        fault;
    preset_idx_t cur_preset;

    modport master (
        output lock, req, req_preset,
        input  pll_reset, idsel, fbdsel, odsel, sys_reset, ready, fault, cur_preset
    );

    modport slave (
        input  lock, req, req_preset,
        output pll_reset, idsel, fbdsel, odsel, sys_reset, ready, fault, cur_preset
    );

endinterface

// File: rtl/pll_lock_sync.sv
// -----------------------------------------------------------------------------
// pll_lock_sync
// Flop chain bringing the asynchronous PLL LOCK into the clk domain.
//   clk    : reference clock
//   reset  : synchronous, active high; clears the chain
//   lock   : asynchronous LOCK from the PLL
//   lock_s : synchronised LOCK, SYNC_STAGES cycles behind lock
// -----------------------------------------------------------------------------
module pll_lock_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic lock,
    output logic lock_s
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift lock in at bit 0; the last stage is the only one used.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], lock};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_seq_ctrl.sv
// -----------------------------------------------------------------------------
// pll_seq_ctrl
// Sequencer for the rPLL in dynamic-select mode, clocked by the 18 MHz
// crystal. Applies one of four presets, pulses PLL RESET, waits for a
// stable LOCK and then releases the core reset. Presets may be re-selected
// from RUN or FAULT.
//   clk   : 18 MHz reference clock
//   reset : synchronous, active high
//   bus   : pll_seq_ctrl_if.slave (lock, req, req_preset in;
//           pll_reset, idsel, fbdsel, odsel, sys_reset, ready, fault,
//           cur_preset out; all outputs registered)
// Optional macro PLL_AUTORETRY_EN: a lock timeout re-resets the PLL and
// FAULT is only entered after MAX_RETRY failed attempts.
// -----------------------------------------------------------------------------
module pll_seq_ctrl
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65535,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned SYNC_STAGES   = 2
`ifdef PLL_AUTORETRY_EN
    ,
    parameter int unsigned MAX_RETRY     = 3
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    pll_seq_ctrl_if.slave        bus
);

    localparam cnt_t RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam cnt_t TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam cnt_t STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

`ifdef PLL_AUTORETRY_EN
    localparam int unsigned RETRY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);

    logic [RETRY_W-1:0] retry_q, retry_d;
`endif

    state_t      state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    preset_idx_t preset_q, preset_d;
    preset_t     sel_q, sel_d;
    logic        load_sel;
    logic        pll_reset_q, pll_reset_d;
    logic        sys_reset_q, sys_reset_d;
    logic        ready_q, ready_d;
    logic        fault_q, fault_d;
    logic        lock_s;

    pll_lock_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk    (clk),
        .reset  (reset),
        .lock   (bus.lock),
        .lock_s (lock_s)
    );

    // State, counter, preset and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            preset_q    <= '0;
            sel_q       <= PRESET_TBL[0];
            pll_reset_q <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
`ifdef PLL_AUTORETRY_EN
            retry_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            preset_q    <= preset_d;
            sel_q       <= sel_d;
            pll_reset_q <= pll_reset_d;
            sys_reset_q <= sys_reset_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
`ifdef PLL_AUTORETRY_EN
            retry_q     <= retry_d;
`endif
        end
    end

    // Next-state logic; outputs are decoded from the next state so they
    // change on the same edge as the state they belong to.
    always_comb begin
        state_d  = state_q;
        cnt_d    = sat_inc(cnt_q);
        preset_d = preset_q;
        load_sel = 1'b0;
`ifdef PLL_AUTORETRY_EN
        retry_d  = retry_q;
`endif

        case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end

            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d = '0;
`ifdef PLL_AUTORETRY_EN
                    if (retry_q == RETRY_LAST) begin
                        state_d = FAULT;
                    end else begin
                        retry_d  = retry_q + 1'b1;
                        state_d  = PLL_RST;
                        load_sel = 1'b1;
                    end
`else
                    state_d = FAULT;
`endif
                end
            end

            STABLE: begin
                // Any low sample restarts both the stability and timeout count.
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
`ifdef PLL_AUTORETRY_EN
                    retry_d = '0;
`endif
                end
            end

            RUN, FAULT: begin
                cnt_d = '0;
                // A request outranks lock loss; lock loss re-applies the
                // current preset.
                if (bus.req) begin
                    preset_d = bus.req_preset;
                    state_d  = PLL_RST;
                    load_sel = 1'b1;
`ifdef PLL_AUTORETRY_EN
                    retry_d  = '0;
`endif
                end else if (state_q == RUN && !lock_s) begin
                    state_d  = PLL_RST;
                    load_sel = 1'b1;
                end
            end

            default: begin
                state_d = PLL_RST;
                cnt_d   = '0;
            end
        endcase

        // Selects only move on entry to PLL_RST, while RESET is asserted.
        sel_d       = load_sel ? PRESET_TBL[preset_d] : sel_q;
        pll_reset_d = (state_d == PLL_RST) || (state_d == FAULT);
        sys_reset_d = (state_d != RUN);
        ready_d     = (state_d == RUN);
        fault_d     = (state_d == FAULT);
    end

    assign bus.pll_reset  = pll_reset_q;
    assign bus.sys_reset  = sys_reset_q;
    assign bus.ready      = ready_q;
    assign bus.fault      = fault_q;
    assign bus.cur_preset = preset_q;
    assign bus.idsel      = sel_q.idsel;
    assign bus.fbdsel     = sel_q.fbdsel;
    assign bus.odsel      = sel_q.odsel;

endmodule
